// File: rtl/fan_off_timer_pkg.sv
// Purpose: shared FSM states, BCD field layout and BCD helper functions for the fan off-timer.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package fan_off_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SET  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int DIGIT_W = 4;
   localparam int MMSS_W  = 4 * DIGIT_W;

   // Digit positions inside mmss = {m10, m1, s10, s1}
   localparam int S1_LSB  = 0;
   localparam int S10_LSB = 4;
   localparam int M1_LSB  = 8;
   localparam int M10_LSB = 12;
   localparam int MIN_LSB = M1_LSB;
   localparam int MIN_W   = 2 * DIGIT_W;

   // One-second BCD decrement of mm:ss; 00:00 stays at 00:00.
   function automatic logic [MMSS_W-1:0] bcd_dec_sec(input logic [MMSS_W-1:0] t);
      logic [DIGIT_W-1:0] s1, s10, m1, m10;
      s1  = t[S1_LSB  +: DIGIT_W];
      s10 = t[S10_LSB +: DIGIT_W];
      m1  = t[M1_LSB  +: DIGIT_W];
      m10 = t[M10_LSB +: DIGIT_W];
      bcd_dec_sec = t;
      if (t != '0) begin
         if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
         end else begin
            s1 = 4'd9;
            if (s10 != 4'd0) begin
               s10 = s10 - 4'd1;
            end else begin
               s10 = 4'd5;
               if (m1 != 4'd0) begin
                  m1 = m1 - 4'd1;
               end else begin
                  m1  = 4'd9;
                  m10 = m10 - 4'd1;
               end
            end
         end
         bcd_dec_sec = {m10, m1, s10, s1};
      end
   endfunction

   // BCD minute add with decimal carry, clamped to max_m (BCD ordering is numeric ordering).
   function automatic logic [MIN_W-1:0] bcd_add_min(input logic [MIN_W-1:0]   m,
                                                    input logic [DIGIT_W-1:0] step,
                                                    input logic [MIN_W-1:0]   max_m);
      logic [DIGIT_W:0]   lo;
      logic [DIGIT_W:0]   hi;
      logic [MIN_W-1:0]   sum;
      lo = {1'b0, m[DIGIT_W-1:0]} + {1'b0, step};
      hi = {1'b0, m[MIN_W-1:DIGIT_W]};
      if (lo > 5'd9) begin
         lo = lo - 5'd10;
         hi = hi + 5'd1;
      end
      sum = {hi[DIGIT_W-1:0], lo[DIGIT_W-1:0]};
      if (hi > 5'd9 || sum > max_m) begin
         bcd_add_min = max_m;
      end else begin
         bcd_add_min = sum;
      end
   endfunction

endpackage

// File: rtl/fan_off_timer_bcd_mmss_counter.sv
// Purpose: four-digit BCD mm:ss register with seconds decrement, saturating minute add and clear.
// Latency: one cycle from control inputs to mmss; zero_next is combinational look-ahead.
// Backpressure: none; every control is applied in the cycle it is presented.
module bcd_mmss_counter
   import fan_off_timer_pkg::*;
#(
   parameter logic [MIN_W-1:0]   MAX_MIN  = 8'h99,
   parameter logic [DIGIT_W-1:0] STEP_MIN = 4'h1
) (
   input  logic              clk,
   input  logic              reset_p,
   input  logic              clr,
   input  logic              dec,
   input  logic              add_min,
   output logic [MMSS_W-1:0] mmss,
   output logic              zero_next
);

   logic [MMSS_W-1:0] cnt_q;
   logic [MMSS_W-1:0] cnt_d;

   // Next count: decrement first, then add minutes, clear overrides both.
   always_comb begin
      cnt_d = cnt_q;
      if (dec) begin
         cnt_d = bcd_dec_sec(cnt_d);
      end
      if (add_min) begin
         cnt_d[MIN_LSB +: MIN_W] = bcd_add_min(cnt_d[MIN_LSB +: MIN_W], STEP_MIN, MAX_MIN);
      end
      if (clr) begin
         cnt_d = '0;
      end
      zero_next = (cnt_d == '0);
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset_p) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign mmss = cnt_q;

endmodule

// File: rtl/fan_off_timer.sv
// Purpose: fan off-timer FSM (IDLE/SET/RUN/DONE) gating the fan and raising timeout/alarm.
// Latency: one cycle; every input sampled at an edge is visible on the registered outputs after it.
// Backpressure: none; button pulses and tick_sec are acted on in the cycle they arrive.
module fan_off_timer
   import fan_off_timer_pkg::*;
#(
   parameter logic [MIN_W-1:0]   MAX_MIN  = 8'h99,
   parameter logic [DIGIT_W-1:0] STEP_MIN = 4'h1
) (
   input  logic              clk,
   input  logic              reset_p,
   input  logic              tick_sec,
   input  logic              btn_add,
   input  logic              btn_start,
   input  logic              btn_clear,
   output logic [MMSS_W-1:0] mmss,
   output logic              run,
   output logic              timeout,
   output logic              alarm,
   output logic [1:0]        state
);

   state_e state_q, state_d;
   logic   run_q, run_d;
   logic   timeout_q, timeout_d;
   logic   alarm_q, alarm_d;

   logic   cnt_clr;
   logic   cnt_dec;
   logic   cnt_add;
   logic   cnt_zero_next;

   bcd_mmss_counter #(
      .MAX_MIN  (MAX_MIN),
      .STEP_MIN (STEP_MIN)
   ) u_cnt (
      .clk       (clk),
      .reset_p   (reset_p),
      .clr       (cnt_clr),
      .dec       (cnt_dec),
      .add_min   (cnt_add),
      .mmss      (mmss),
      .zero_next (cnt_zero_next)
   );

   // Next state and counter controls; clear wins everywhere, expiry beats pause in RUN.
   always_comb begin
      state_d   = state_q;
      cnt_clr   = 1'b0;
      cnt_dec   = 1'b0;
      cnt_add   = 1'b0;
      timeout_d = 1'b0;
      if (btn_clear) begin
         cnt_clr = 1'b1;
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (btn_add) begin
                  cnt_add = 1'b1;
                  state_d = SET;
               end
            end
            SET: begin
               cnt_add = btn_add;
               if (btn_start) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               cnt_dec = tick_sec;
               cnt_add = btn_add;
               if (tick_sec && cnt_zero_next) begin
                  state_d   = DONE;
                  timeout_d = 1'b1;
               end else if (btn_start) begin
                  state_d = SET;
               end
            end
            DONE: begin
               // Acknowledge only; the count is already zero and no time is added.
               if (btn_start || btn_add) begin
                  cnt_clr = 1'b1;
                  state_d = IDLE;
               end
            end
            default: begin
               cnt_clr = 1'b1;
               state_d = IDLE;
            end
         endcase
      end
      run_d   = (state_d == RUN);
      alarm_d = (state_d == DONE);
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset_p) begin
         state_q   <= IDLE;
         run_q     <= 1'b0;
         timeout_q <= 1'b0;
         alarm_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         timeout_q <= timeout_d;
         alarm_q   <= alarm_d;
      end
   end

   assign state   = state_q;
   assign run     = run_q;
   assign timeout = timeout_q;
   assign alarm   = alarm_q;

endmodule

// File: tb/tb_fan_off_timer.sv
// Purpose: directed self-checking bench for fan_off_timer (vector table plus corner sequences).
// Latency: outputs checked 1 time unit after each active edge.
// Backpressure: n/a.
module tb_fan_off_timer;

   logic        clk = 1'b0;
   logic        reset_p = 1'b1;
   logic        tick_sec = 1'b0;
   logic        btn_add = 1'b0;
   logic        btn_start = 1'b0;
   logic        btn_clear = 1'b0;
   logic [15:0] mmss;
   logic        run;
   logic        timeout;
   logic        alarm;
   logic [1:0]  state;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SET  = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   fan_off_timer #(
      .MAX_MIN  (8'h99),
      .STEP_MIN (4'h1)
   ) dut (
      .clk       (clk),
      .reset_p   (reset_p),
      .tick_sec  (tick_sec),
      .btn_add   (btn_add),
      .btn_start (btn_start),
      .btn_clear (btn_clear),
      .mmss      (mmss),
      .run       (run),
      .timeout   (timeout),
      .alarm     (alarm),
      .state     (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        a, s, c, t;
      logic [15:0] m;
      logic [1:0]  st;
      logic        r, to, al;
   } vec_t;

   vec_t tbl [18];

   // One clock with the given pulses, then release them.
   task automatic step(input logic a, input logic s, input logic c, input logic t);
      btn_add = a; btn_start = s; btn_clear = c; tick_sec = t;
      @(posedge clk); #1;
      btn_add = 1'b0; btn_start = 1'b0; btn_clear = 1'b0; tick_sec = 1'b0;
   endtask

   task automatic steps(input int n, input logic a, input logic s, input logic t);
      for (int k = 0; k < n; k++) step(a, s, 1'b0, t);
   endtask

   task automatic chk(input string nm, input logic [15:0] m, input logic [1:0] st,
                      input logic r, input logic to, input logic al);
      logic [20:0] got, exp;
      got = {mmss, state, run, timeout, alarm};
      exp = {m, st, r, to, al};
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got mmss=%h state=%0d run=%b timeout=%b alarm=%b, want mmss=%h state=%0d run=%b timeout=%b alarm=%b",
                  nm, mmss, state, run, timeout, alarm, m, st, r, to, al);
      end
   endtask

   task automatic do_reset();
      reset_p = 1'b1;
      @(posedge clk); #1;
      reset_p = 1'b0;
   endtask

   initial begin
      //            a  s  c  t   mmss     state   r  to al
      tbl[0]  = '{1, 0, 0, 0, 16'h0100, S_SET,  0, 0, 0};
      tbl[1]  = '{1, 0, 0, 0, 16'h0200, S_SET,  0, 0, 0};
      tbl[2]  = '{1, 0, 0, 0, 16'h0300, S_SET,  0, 0, 0};
      tbl[3]  = '{0, 1, 0, 0, 16'h0300, S_RUN,  1, 0, 0};
      tbl[4]  = '{0, 0, 0, 1, 16'h0259, S_RUN,  1, 0, 0};
      tbl[5]  = '{1, 0, 0, 1, 16'h0358, S_RUN,  1, 0, 0};
      tbl[6]  = '{0, 1, 0, 0, 16'h0358, S_SET,  0, 0, 0};
      tbl[7]  = '{0, 0, 0, 1, 16'h0358, S_SET,  0, 0, 0};
      tbl[8]  = '{0, 1, 0, 0, 16'h0358, S_RUN,  1, 0, 0};
      tbl[9]  = '{0, 0, 1, 1, 16'h0000, S_IDLE, 0, 0, 0};
      tbl[10] = '{0, 1, 0, 0, 16'h0000, S_IDLE, 0, 0, 0};
      tbl[11] = '{0, 0, 0, 1, 16'h0000, S_IDLE, 0, 0, 0};
      tbl[12] = '{1, 0, 0, 0, 16'h0100, S_SET,  0, 0, 0};
      tbl[13] = '{0, 1, 0, 0, 16'h0100, S_RUN,  1, 0, 0};
      tbl[14] = '{0, 0, 0, 1, 16'h0059, S_RUN,  1, 0, 0};
      tbl[15] = '{1, 0, 0, 0, 16'h0159, S_RUN,  1, 0, 0};
      tbl[16] = '{0, 0, 1, 0, 16'h0000, S_IDLE, 0, 0, 0};
      tbl[17] = '{1, 0, 1, 0, 16'h0000, S_IDLE, 0, 0, 0};

      reset_p = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 16'h0000, S_IDLE, 0, 0, 0);
      reset_p = 1'b0;

      // Vector table
      for (int i = 0; i < 18; i++) begin
         step(tbl[i].a, tbl[i].s, tbl[i].c, tbl[i].t);
         chk($sformatf("vec%0d", i), tbl[i].m, tbl[i].st, tbl[i].r, tbl[i].to, tbl[i].al);
      end

      // Basic: 3 minutes counted fully down
      do_reset();
      chk("reset_again", 16'h0000, S_IDLE, 0, 0, 0);
      steps(3, 1, 0, 0);
      chk("basic_set", 16'h0300, S_SET, 0, 0, 0);
      step(0, 1, 0, 0);
      chk("basic_start", 16'h0300, S_RUN, 1, 0, 0);
      steps(179, 0, 0, 1);
      chk("basic_179", 16'h0001, S_RUN, 1, 0, 0);
      step(0, 0, 0, 1);
      chk("basic_expire", 16'h0000, S_DONE, 0, 1, 1);
      step(0, 0, 0, 0);
      chk("basic_timeout_1cyc", 16'h0000, S_DONE, 0, 0, 1);
      step(0, 0, 0, 1);
      chk("done_tick_ignored", 16'h0000, S_DONE, 0, 0, 1);
      step(0, 1, 0, 0);
      chk("done_ack_start", 16'h0000, S_IDLE, 0, 0, 0);

      // Borrow across tens of minutes
      step(0, 0, 1, 0);
      steps(10, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      chk("borrow_1000", 16'h0959, S_RUN, 1, 0, 0);

      // Saturation at 99 minutes
      step(0, 0, 1, 0);
      steps(105, 1, 0, 0);
      chk("sat_105", 16'h9900, S_SET, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("sat_more", 16'h9900, S_SET, 0, 0, 0);

      // Pause at 02:30
      step(0, 0, 1, 0);
      steps(3, 1, 0, 0);
      step(0, 1, 0, 0);
      steps(30, 0, 0, 1);
      chk("pause_0230", 16'h0230, S_RUN, 1, 0, 0);
      step(0, 1, 0, 0);
      chk("pause_set", 16'h0230, S_SET, 0, 0, 0);
      steps(10, 0, 0, 1);
      chk("pause_hold", 16'h0230, S_SET, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      chk("pause_resume", 16'h0229, S_RUN, 1, 0, 0);

      // Simultaneous tick+add at 00:01, then tick+start at 00:01
      step(0, 0, 1, 0);
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      steps(59, 0, 0, 1);
      chk("sim_0001", 16'h0001, S_RUN, 1, 0, 0);
      step(1, 0, 0, 1);
      chk("sim_tick_add", 16'h0100, S_RUN, 1, 0, 0);
      steps(59, 0, 0, 1);
      step(0, 1, 0, 1);
      chk("sim_tick_start", 16'h0000, S_DONE, 0, 1, 1);
      step(1, 0, 0, 0);
      chk("done_ack_add", 16'h0000, S_IDLE, 0, 0, 0);

      // Reset mid-run at 04:12
      steps(5, 1, 0, 0);
      step(0, 1, 0, 0);
      steps(48, 0, 0, 1);
      chk("pre_reset_0412", 16'h0412, S_RUN, 1, 0, 0);
      reset_p = 1'b1;
      tick_sec = 1'b1;
      @(posedge clk); #1;
      reset_p = 1'b0;
      tick_sec = 1'b0;
      chk("reset_midrun", 16'h0000, S_IDLE, 0, 0, 0);
      step(0, 0, 0, 1);
      chk("after_reset", 16'h0000, S_IDLE, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fan_off_timer.md
# fan_off_timer

Countdown off-timer for the multifunctional fan. Consumes the one-cycle `tick_sec` enable produced by the divider chain and pulse-shaped button inputs, keeps a BCD mm:ss remaining time, and gates the fan. On expiry it issues a one-cycle `timeout` pulse and holds `alarm` until acknowledged. The BCD output drives the FND display path directly.

## Interface
- `MAX_MIN`, default 99: minute saturation limit. BCD, 1..99.
- `STEP_MIN`, default 1: minutes added per `btn_add`. BCD, 1..9.
- `clk`, in, 1: system clock.
- `reset_p`, in, 1: reset, synchronous, active-high.
- `tick_sec`, in, 1: one-`clk` enable, once per second, from the divider chain.
- `btn_add`, in, 1: one-cycle pulse; add `STEP_MIN` minutes.
- `btn_start`, in, 1: one-cycle pulse; start/pause toggle.
- `btn_clear`, in, 1: one-cycle pulse; cancel and zero.
- `mmss`, out, 16: BCD remaining time `{m10, m1, s10, s1}`.
- `run`, out, 1: fan gate; high only in RUN.
- `timeout`, out, 1: one-cycle pulse on expiry.
- `alarm`, out, 1: level, high in DONE.
- `state`, out, 2: current FSM state, for the display mux.

## Operation
- States and encodings: IDLE=0, SET=1, RUN=2, DONE=3. Reset forces IDLE.
- `btn_clear` has top priority in every state. It zeroes `mmss`, moves to IDLE, and drops `run` and `alarm`.
- **IDLE:** `mmss` = 0000.
  - `btn_add`: `mmss` = `STEP_MIN`:00, go to SET.
  - `btn_start`: ignored.
- **SET (armed, paused):**
  - `btn_add`: minutes += `STEP_MIN`, saturating at `MAX_MIN`; seconds unchanged.
  - `btn_start`: go to RUN.
  - `tick_sec`: ignored.
- **RUN:**
  - `tick_sec` decrements one second. When s=00 and m>0, the result is (m−1):59. Each BCD digit wraps correctly: s1 0→9 borrows; s10 0→5 borrows.
  - `btn_start`: go to SET, count held.
  - `btn_add`: adds minutes with saturation, as in SET.
- **Expiry:** a tick that takes the count from 00:01 to 00:00 moves to DONE and pulses `timeout`.
- **DONE:** `mmss` = 0000, `alarm` = 1.
  - `btn_start` or `btn_add`: acknowledge, go to IDLE. This does not add time.
  - `tick_sec`: ignored.
- **Simultaneous `tick_sec` + `btn_add` in RUN:** apply both in the same cycle, decrement then add. Examples: 05:00 → 05:59; 00:01 → `STEP_MIN`:00, with no expiry.
- **Simultaneous `tick_sec` + `btn_start` in RUN:** apply the decrement, then pause. If that decrement reaches 00:00, expiry wins: go to DONE and pulse `timeout`.
- **`btn_add` at saturation:** with m=`MAX_MIN`, `mmss` is unchanged.
- **Minute arithmetic:** BCD add with decimal carry; the result is clamped to `MAX_MIN` before registering.

## Timing
- All outputs are registered. An input sampled at edge N is reflected after edge N. Latency is one cycle.
- Reset values: `mmss`=16'h0000, `run`=0, `timeout`=0, `alarm`=0, `state`=0.
- `timeout` is high for exactly one cycle: the first cycle with `state`=DONE.
- `run` falls on the same edge that `state` leaves RUN.
- Inputs are assumed to be single-cycle pulses. A held-high button is acted on every cycle and is the caller's responsibility.
- Reset asserted mid-RUN: at the next edge all outputs return to reset values, with no `timeout` pulse.

## Structure
- Shared package:
  - state localparams IDLE/SET/RUN/DONE;
  - the BCD digit width (4);
  - the `mmss` field positions.
- Sub-module `bcd_mmss_counter`: holds the four BCD digits and implements:
  - `dec` (mod-60 seconds with borrow into minutes);
  - `add_min` (with saturation);
  - `clr`;
  - a `zero_next` flag.
- `fan_off_timer` contains the FSM and output registers only.

## Test plan
- **Basic:** Reset, then `btn_add`×3 → `mmss`=0300, `state`=SET. Then `btn_start` → `run`=1. After 180 ticks: `timeout` is high for exactly 1 cycle, `mmss`=0000, `alarm`=1, `run`=0.
- **Borrow chain:** From 01:00, one tick → 00:59. From 10:00, one tick → 09:59.
- **Saturation:** With `MAX_MIN`=99, `btn_add`×105 → `mmss`=9900. A further `btn_add` leaves it unchanged.
- **Pause:** Running at 02:30, `btn_start` → SET. 10 ticks leave 02:30 unchanged. `btn_start` resumes; the next tick gives 02:29.
- **Simultaneous events:** At 00:01 in RUN, `tick_sec`+`btn_add` in the same cycle → 01:00 with no `timeout`. At 00:01, `tick_sec`+`btn_start` → DONE with `timeout` pulsed. `btn_clear`+`tick_sec` → IDLE, 0000.
- **Acknowledge and reset mid-run:** In DONE, `btn_start` → IDLE, `alarm`=0, `mmss`=0000. Separately, `reset_p` high for 1 cycle mid-RUN at 04:12 → all outputs at reset values on the next cycle, with no `timeout`.
